// File: rtl/lcd_cmd_issuer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_cmd_issuer_if                                            |
// | Description : Signal bundle between the host sequencer, the command        |
// |               issuer and the LCD controller command port.                  |
// |   in_cmd/in_valid/in_ready : enqueue handshake from the upstream producer  |
// |   cmd/cmd_valid            : one-cycle command strobe to the controller    |
// |   busy/done                : controller status                             |
// |   finished/timeout/illegal : sticky completion and error flags             |
// |   issued_cnt               : saturating count of issued strobes            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface lcd_cmd_issuer_if;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       finished;
  logic       timeout;
  logic       illegal;
  logic [7:0] issued_cnt;

  // Issuer side
  modport master (
    input  in_cmd, in_valid, busy, done,
    output in_ready, cmd, cmd_valid, finished, timeout, illegal, issued_cnt
  );

  // Producer / controller side
  modport slave (
    output in_cmd, in_valid, busy, done,
    input  in_ready, cmd, cmd_valid, finished, timeout, illegal, issued_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lcd_cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_cmd_issuer                                               |
// | Description : Buffers 4-bit LCD commands in a FIFO and issues them to the  |
// |               LCD controller one at a time, honouring its busy handshake.  |
// |               After the Write command (code 0) it waits for done and       |
// |               reports completion or timeout.                               |
// | Ports       : clk   - clock, rising edge                                   |
// |               reset - asynchronous, active-high                            |
// |               bus   - lcd_cmd_issuer_if.master (enqueue port, controller   |
// |                       command port, status flags, issue counter)           |
// | Parameters  : DEPTH   - FIFO depth, power of two, >= 2                     |
// |               TIMEOUT - cycles allowed in WAIT_DONE (8..65535)             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcd_cmd_issuer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  lcd_cmd_issuer_if.master bus
);

  localparam int          c_AW        = $clog2(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};
  localparam logic [15:0] c_TOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  c_CMD_WRITE = 4'd0;

  localparam logic [2:0] c_ST_BOOT   = 3'd0;
  localparam logic [2:0] c_ST_IDLE   = 3'd1;
  localparam logic [2:0] c_ST_ISSUE  = 3'd2;
  localparam logic [2:0] c_ST_GAP    = 3'd3;
  localparam logic [2:0] c_ST_WAIT   = 3'd4;
  localparam logic [2:0] c_ST_FINISH = 3'd5;
  localparam logic [2:0] c_ST_TOUT   = 3'd6;

  // State
  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;

  // FIFO storage and pointers (one extra bit to tell full from empty)
  logic [3:0]    r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;

  // Datapath registers
  logic [3:0]    r_cmd;
  logic [15:0]   r_tcnt;
  logic          r_illegal;
  logic [7:0]    r_issued;

  // Combinational helpers
  logic          w_empty;
  logic          w_full;
  logic          w_open;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_code_bad;
  logic          w_push_wr;
  logic          w_pop;
  logic [15:0]   w_tcnt_nxt;
  logic          w_cmd_valid;
  logic          w_finished;
  logic          w_timeout;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // Full blocks pushes even when a pop happens in the same cycle, which keeps
  // in_ready free of any dependency on busy.
  assign w_in_ready = w_open && !w_full;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Codes 12..15 are taken off the bus but never stored.
  assign w_code_bad = (bus.in_cmd[3:2] == 2'b11);
  assign w_push_wr  = w_accept && !w_code_bad;

  assign w_pop = (r_state == c_ST_IDLE) && !w_empty && !bus.busy;

  assign w_tcnt_nxt = r_tcnt + 16'd1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Hold off while the controller loads its ROM.
      c_ST_BOOT:   if (!bus.busy) w_state_nxt = c_ST_IDLE;
      c_ST_IDLE:   if (w_pop)     w_state_nxt = c_ST_ISSUE;
      c_ST_ISSUE:  w_state_nxt = (r_cmd == c_CMD_WRITE) ? c_ST_WAIT : c_ST_GAP;
      // busy is deliberately ignored here: the controller raises it only in
      // this cycle as its acknowledge of the strobe.
      c_ST_GAP:    w_state_nxt = c_ST_IDLE;
      // done wins over the counter. The counter reaches TIMEOUT-1 on the edge
      // that leaves WAIT_DONE, so the timeout flag appears TIMEOUT cycles
      // after the Write strobe.
      c_ST_WAIT: begin
        if (bus.done) begin
          w_state_nxt = c_ST_FINISH;
        end else if (w_tcnt_nxt == c_TOUT_LAST) begin
          w_state_nxt = c_ST_TOUT;
        end
      end
      c_ST_FINISH: w_state_nxt = c_ST_FINISH;
      c_ST_TOUT:   w_state_nxt = c_ST_TOUT;
      default:     w_state_nxt = c_ST_BOOT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cmd_valid = 1'b0;
    w_finished  = 1'b0;
    w_timeout   = 1'b0;
    w_open      = 1'b0;
    case (r_state)
      c_ST_IDLE:   w_open = 1'b1;
      c_ST_ISSUE: begin
        w_open      = 1'b1;
        w_cmd_valid = 1'b1;
      end
      c_ST_GAP:    w_open = 1'b1;
      c_ST_WAIT:   w_open = 1'b1;
      c_ST_FINISH: w_finished = 1'b1;
      c_ST_TOUT:   w_timeout  = 1'b1;
      default: begin
        w_open = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (contents need no reset; pointers define validity)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push_wr) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= bus.in_cmd;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, command register, counters and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cmd     <= 4'd0;
      r_tcnt    <= 16'd0;
      r_illegal <= 1'b0;
      r_issued  <= 8'd0;
    end else begin
      if (w_push_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      if (w_pop) begin
        r_cmd    <= r_mem[r_rd_ptr[c_AW-1:0]];
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end

      if (w_accept && w_code_bad) begin
        r_illegal <= 1'b1;
      end

      if ((r_state == c_ST_ISSUE) && (r_issued != 8'hFF)) begin
        r_issued <= r_issued + 8'd1;
      end

      // Zero outside WAIT_DONE so every entry starts from a clean count.
      if (r_state == c_ST_WAIT) begin
        r_tcnt <= w_tcnt_nxt;
      end else begin
        r_tcnt <= 16'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.cmd_valid  = w_cmd_valid;
  assign bus.cmd        = w_cmd_valid ? r_cmd : 4'd0;
  assign bus.finished   = w_finished;
  assign bus.timeout    = w_timeout;
  assign bus.illegal    = r_illegal;
  assign bus.issued_cnt = r_issued;

endmodule
`default_nettype wire

// File: doc/lcd_cmd_issuer.md
# lcd_cmd_issuer

Host-side command initiator for the LCD image controller. Buffers a queue of 4-bit LCD commands from an upstream producer, then drives `cmd`/`cmd_valid` toward the controller one command at a time, obeying its `busy` handshake. After issuing the Write command (code 0) it waits for the controller's `done` and reports completion or timeout. It sits between the test/host sequencer and the LCD controller's command port.

## Interface

- `DEPTH`, 16: command FIFO depth, power of 2, ≥2.
- `TIMEOUT`, 200: maximum cycles spent in WAIT_DONE before flagging timeout (8..65535).
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_cmd`  in  4  command code to enqueue.
- `in_valid`  in  1  enqueue request; accepted when `in_valid && in_ready`.
- `in_ready`  out  1  1 when the FIFO has room and state is not FINISH/TIMEOUT.
- `cmd`  out  4  command to the controller; forced to 4'd0 whenever `cmd_valid` is 0.
- `cmd_valid`  out  1  one-cycle issue strobe.
- `busy`  in  1  controller busy.
- `done`  in  1  controller write-back complete (level).
- `finished`  out  1  sticky; set when `done` is seen after Write was issued.
- `timeout`  out  1  sticky; set when WAIT_DONE exceeds TIMEOUT.
- `illegal`  out  1  sticky; set when an accepted push carries a code 12..15.
- `issued_cnt`  out  8  count of `cmd_valid` pulses, saturating at 255.

## Operation

- FIFO: DEPTH entries, pointers one bit wider than the address. Codes 12..15 are accepted but dropped (not written) and set `illegal`. With the FIFO full, `in_ready`=0 even if a pop occurs in the same cycle. A push at edge t is poppable from cycle t+1.
- States: BOOT, IDLE, ISSUE, GAP, WAIT_DONE, FINISH, TOUT.
- BOOT: entered from reset. Leaves to IDLE in the first cycle where `busy`=0, covering the controller's ROM load.
- IDLE: if FIFO non-empty and `busy`=0, pop the head into the `cmd` register and go to ISSUE. Otherwise stay.
- ISSUE: `cmd_valid`=1 for exactly this cycle; `issued_cnt` increments. Next state is WAIT_DONE if `cmd`=0, else GAP.
- GAP: one cycle with `cmd_valid`=0. `busy` is ignored here because the controller raises it only in this cycle. Then go to IDLE.
- WAIT_DONE: the timeout counter (16-bit) is cleared on entry and increments each cycle.
  - `done`=1 takes priority over the counter: go to FINISH.
  - If the counter equals TIMEOUT-1 with `done`=0, go to TOUT.
- FINISH: `finished`=1; no further issue. Remaining FIFO content is retained but never popped. Exit only by reset.
- TOUT: `timeout`=1; no further issue. Exit only by reset.
- Reset mid-operation clears the FIFO, all flags and the counter, and returns to BOOT. A `cmd_valid` pulse in progress is cut off immediately, since the outputs are asynchronously cleared.

## Timing

- Reset values: `cmd`=0, `cmd_valid`=0, `in_ready`=0 (BOOT; it is 1 once in IDLE/ISSUE/GAP/WAIT_DONE with room), `finished`=0, `timeout`=0, `illegal`=0, `issued_cnt`=0.
- All outputs are registered or decoded from the state register only; no combinational path from `busy`/`done` to outputs.
- Issue latency: IDLE with non-empty FIFO and `busy`=0 at cycle t gives `cmd_valid`=1 in cycle t+1.
- Back-to-back non-Write commands issue every 3 cycles: ISSUE, GAP, IDLE.
- Write issued in cycle t puts the block in WAIT_DONE from t+1. If `done` first goes high in cycle d, `finished` rises in cycle d+1.
- `in_ready` in FINISH/TOUT is 0; pushes are ignored.

## Test plan

- Boot hold: hold `busy`=1 for 70 cycles after reset with 3 commands queued. Expect no `cmd_valid` until `busy` falls; first `cmd_valid` 2 cycles after the first `busy`=0 cycle.
- Streaming: queue 1,2,3,4 with a controller model (busy=1 the cycle after each strobe). Expect `cmd_valid` pulses 3 cycles apart with `cmd`=1,2,3,4, `cmd`=0 between pulses, and `issued_cnt`=4.
- Write/done: queue 5,0,7. Expect pulses for 5 and then 0 only. Drive `done`=1 40 cycles later: `finished`=1 next cycle, 7 never issued, `in_ready`=0.
- Timeout: TIMEOUT=16, queue 0, never assert `done`. Expect `timeout`=1 exactly 16 cycles after the ISSUE cycle, `finished`=0.
- FIFO full/illegal: DEPTH=4, `busy` held 1, push 6 entries including code 13. Expect `in_ready`=0 after 4 legal entries stored, `illegal`=1, and code 13 never issued.
- Mid-run reset: assert reset during GAP after 2 issues. Expect all outputs at reset values immediately, FIFO empty, `issued_cnt`=0 and BOOT behaviour afterwards.
